pll_lock_rst_seq: RTL

PLL_LOCK_RST_SEQ -- requirements
Module: pll_lock_rst_seq

---
 rtl/pll_lock_rst_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/pll_lock_rst_seq.sv
// Brings up a PLL: pulses pll_rst, qualifies a stable lock, then releases sys_rst; re-enters lock wait on loss.
// Optional macro PLL_LOCK_RETRY_EN adds a WAIT_LOCK timeout that re-pulses pll_rst and counts retries.
module pll_lock_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       clk_ready,
  output logic [7:0] loss_cnt,
  output logic [7:0] retry_cnt
);

  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);

  if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 65535 ||
      LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535 ||
      LOCK_TIMEOUT_CYCLES < 1 || LOCK_TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("pll_lock_rst_seq: cycle parameters must lie in 1..65535");
  end

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        lock_m;
  logic        lock_s;
  logic        loss_evt;

  // extlock is asynchronous to refclk; only lock_s feeds decisions.
  always_ff @(posedge refclk) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= extlock;
      lock_s <= lock_m;
    end
  end

`ifdef PLL_LOCK_RETRY_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
  logic retry_evt;
`endif

  always_comb begin
    state_nxt = state;
    loss_evt  = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
    retry_evt = 1'b0;
`endif
    unique case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_nxt = STABLE;
        end
`ifdef PLL_LOCK_RETRY_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt = PLL_RST;
          retry_evt = 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          loss_evt  = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      clk_ready <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      pll_rst   <= (state_nxt == PLL_RST);
      sys_rst   <= (state_nxt != RUN);
      clk_ready <= (state_nxt == RUN);
      if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
  end

`ifdef PLL_LOCK_RETRY_EN
  always_ff @(posedge refclk) begin
    if (reset) retry_cnt <= '0;
    else if (retry_evt && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
  end
`else
  assign retry_cnt = 8'd0;
`endif

endmodule
